mux4_arbiter: RTL and testbench
===============================

# mux4_arbiter

Round-robin arbiter and sequencer for the 4:1 single-bit multiplexer datapath. Four requesters each own one data input (a, b, c, d) and compete for the shared output y. The block grants exactly one requester at a time and drives the mux selects s1/s0 from registered state. It gates y to 0 while no grant is held. An optional hold-timeout forces fair rotation when a requester holds the output too long.

## Interface
- MAX_HOLD, 16, maximum consecutive grant cycles before forced release (timeout build only); legal range 2..256
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  synchronous, active-low reset
- req  input  4  request lines; bit i belongs to requester i (0=a, 1=b, 2=c, 3=d)
- a, b, c, d  input  1 each  requester data inputs
- gnt  output  4  one-hot grant, registered; all zero when idle
- s1, s0  output  1 each  registered mux selects; {s1,s0} = index of granted requester
- busy  output  1  registered; high while any grant is held
- y  output  1  selected data; combinational from a..d through registered s1/s0; forced 0 when busy=0

## Operation
- Clock and reset are fixed: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values (rst_n sampled low at a rising edge): gnt=4'b0000, s1=0, s0=0, busy=0, y=0, state=IDLE, last pointer=3, hold counter=0.
- Two states, IDLE and GRANT.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise grant the first set bit searching upward, with wrap-around, from (last+1) mod 4.
  - Load gnt, s1/s0 and last with that index; clear the hold counter; set busy; go to GRANT.
- GRANT:
  - While req[owner]=1, stay in GRANT; the hold counter increments.
  - When req[owner]=0 is sampled: clear gnt, clear busy, go to IDLE. last keeps the released index.
  - Requests from other requesters never pre-empt the owner, except through the timeout.
- s1/s0 retain the last granted index while in IDLE. y is still 0 in IDLE because busy=0.
- Simultaneous requests: resolved solely by the round-robin order from last+1.
- The mux function is y = s1 ? (s0 ? d : c) : (s0 ? b : a), ANDed with busy.
- Reset asserted mid-grant: all outputs return to reset values at that edge. After reset, requester 0 has first priority.

## Timing
- Grant latency: req sampled high at edge k in IDLE -> gnt/s1/s0/busy valid after edge k. y follows in the same cycle.
- Release: req[owner] sampled low at edge m -> gnt=0 and busy=0 after edge m.
- After any release there is exactly one IDLE cycle. The earliest next grant is after edge m+1, even if other requests are pending.
- No combinational path from req to any output. y depends combinationally only on a..d and registered state.

## Configuration
- Macro: MUX4_ARB_TIMEOUT_EN.
- Defined:
  - The hold counter is active.
  - If hold counter == MAX_HOLD-1 at an edge and any other req bit is set, the grant is forced off at that edge. The owner therefore holds for exactly MAX_HOLD cycles, and the block enters IDLE.
  - With no other request pending, the counter wraps to 0 and the grant continues.
  - A force-released requester that keeps req high is treated as a new request in round-robin order.
- Undefined:
  - No hold counter logic is present and MAX_HOLD is ignored.
  - A grant persists until the owner drops req.

## Test plan
- Reset: drive req=4'b1111 with rst_n=0 for 3 cycles -> gnt=0, busy=0, y=0, {s1,s0}=0. One edge after rst_n=1 -> gnt=4'b0001.
- Single requester: req=4'b0100, c=1 -> one edge later gnt=4'b0100, {s1,s0}=2'b10, y=1. Toggle c -> y follows c in the same cycle. Drop req -> gnt=0 and y=0 after the next edge.
- Round-robin: hold req=4'b1111, and each owner drops its req for one cycle after being granted -> grant order 0,1,2,3,0, with one IDLE cycle between each grant.
- Non-preemption (macro undefined): owner 1 holds 40 cycles while req[3]=1 -> gnt stays 4'b0010 throughout. Release -> gnt=4'b1000 two edges later.
- Timeout (macro defined, MAX_HOLD=4): req=4'b0011 held constantly -> gnt=0001 for exactly 4 cycles, then 1 idle cycle, then 0010 for 4 cycles, repeating. req=4'b0001 alone -> grant never drops.
- Mid-grant reset: rst_n=0 for one edge while gnt=4'b1000 -> all outputs return to reset values. With req=4'b1001 still high, the next grant is 4'b0001.

Source files
------------

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter driving the select lines of a 4:1 single-bit mux.
// Define MUX4_ARB_TIMEOUT_EN to force rotation after MAX_HOLD grant cycles.
module mux4_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   output logic [3:0] gnt,
   output logic       s1,
   output logic       s0,
   output logic       busy,
   output logic       y
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_d;
   logic [3:0] gnt_d;
   logic [1:0] sel, sel_d;
   logic [1:0] last, last_d;
   logic [1:0] cand, pick;
   logic       busy_d;
   logic       found;
   logic       drop;

   if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
      $error("MAX_HOLD must be within 2..256");
   end

`ifdef MUX4_ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD);

   logic [CW-1:0] cnt, cnt_d;
   logic          cnt_top;

   assign cnt_top = (cnt == CW'(MAX_HOLD - 1));
`endif

   // First set request at or after last+1, wrapping at 4.
   always_comb begin
      pick  = 2'd0;
      found = 1'b0;
      cand  = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         cand = last + 2'(i);
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      drop = !req[last];
`ifdef MUX4_ARB_TIMEOUT_EN
      if (cnt_top && |(req & ~gnt))
         drop = 1'b1;
`endif
   end

   always_comb begin
      state_d = state;
      gnt_d   = gnt;
      sel_d   = sel;
      last_d  = last;
      busy_d  = busy;
`ifdef MUX4_ARB_TIMEOUT_EN
      cnt_d   = cnt;
`endif
      unique case (state)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
               gnt_d   = 4'b0001 << pick;
               sel_d   = pick;
               last_d  = pick;
               busy_d  = 1'b1;
`ifdef MUX4_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         GRANT: begin
            if (drop) begin
               state_d = IDLE;
               gnt_d   = 4'b0000;
               busy_d  = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
               cnt_d   = '0;
            end else if (cnt_top) begin
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 4'b0000;
         sel   <= 2'd0;
         last  <= 2'd3;
         busy  <= 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
         cnt   <= '0;
`endif
      end else begin
         state <= state_d;
         gnt   <= gnt_d;
         sel   <= sel_d;
         last  <= last_d;
         busy  <= busy_d;
`ifdef MUX4_ARB_TIMEOUT_EN
         cnt   <= cnt_d;
`endif
      end
   end

   assign {s1, s0} = sel;
   assign y = busy & (s1 ? (s0 ? d : c) : (s0 ? b : a));

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed self-checking bench for mux4_arbiter.
// Timeout vectors run when MUX4_ARB_TIMEOUT_EN is defined (MAX_HOLD=4).
module tb_mux4_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       a, b, c, d;
   logic [3:0] gnt;
   logic       s1, s0, busy, y;

   int checks = 0;
   int failures = 0;

   mux4_arbiter #(.MAX_HOLD(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .a    (a),
      .b    (b),
      .c    (c),
      .d    (d),
      .gnt  (gnt),
      .s1   (s1),
      .s0   (s0),
      .busy (busy),
      .y    (y)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] to_exp [15] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                              4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                              4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};

   initial begin
      rst_n = 1'b0;
      req   = 4'b1111;
      a = 1'b1; b = 1'b0; c = 1'b0; d = 1'b0;

      // reset with all requests pending
      repeat (3) tick();
      check("rst_gnt", 8'(gnt), 8'h0);
      check("rst_busy", 8'(busy), 8'h0);
      check("rst_y", 8'(y), 8'h0);
      check("rst_sel", 8'({s1, s0}), 8'h0);
      rst_n = 1'b1;
      tick();
      check("post_rst_gnt", 8'(gnt), 8'h1);
      check("post_rst_y", 8'(y), 8'h1);
      req = 4'b0000;
      tick();
      check("rel_gnt", 8'(gnt), 8'h0);
      check("rel_y", 8'(y), 8'h0);
      tick();

      // single requester c
      a = 1'b0;
      c = 1'b1;
      req = 4'b0100;
      tick();
      check("c_gnt", 8'(gnt), 8'h4);
      check("c_sel", 8'({s1, s0}), 8'h2);
      check("c_y1", 8'(y), 8'h1);
      c = 1'b0;
      #1;
      check("c_y0", 8'(y), 8'h0);
      c = 1'b1;
      #1;
      check("c_y1b", 8'(y), 8'h1);
      req = 4'b0000;
      tick();
      check("c_rel_gnt", 8'(gnt), 8'h0);
      check("c_rel_busy", 8'(busy), 8'h0);
      check("c_rel_y", 8'(y), 8'h0);
      check("c_rel_sel", 8'({s1, s0}), 8'h2);

      // round robin from reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("rr_gnt%0d", k), 8'(gnt), 8'(rr_exp[k]));
         req = 4'b1111 & ~rr_exp[k];
         tick();
         check($sformatf("rr_idle%0d", k), 8'(gnt), 8'h0);
         req = 4'b1111;
      end

      // mid-grant reset
      req = 4'b1000;
      d = 1'b1;
      tick();
      check("mr_gnt", 8'(gnt), 8'h8);
      check("mr_y", 8'(y), 8'h1);
      rst_n = 1'b0;
      req = 4'b1001;
      tick();
      check("mr_rst_gnt", 8'(gnt), 8'h0);
      check("mr_rst_busy", 8'(busy), 8'h0);
      check("mr_rst_y", 8'(y), 8'h0);
      check("mr_rst_sel", 8'({s1, s0}), 8'h0);
      rst_n = 1'b1;
      tick();
      check("mr_next_gnt", 8'(gnt), 8'h1);
      req = 4'b0000;
      tick();
      tick();

`ifdef MUX4_ARB_TIMEOUT_EN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req = 4'b0011;
      for (int k = 0; k < 14; k++) begin
         tick();
         check($sformatf("to_gnt%0d", k), 8'(gnt), 8'(to_exp[k]));
      end
      req = 4'b0001;
      for (int k = 0; k < 12; k++) begin
         tick();
         check($sformatf("to_solo%0d", k), 8'(gnt), 8'h1);
      end
`else
      // non-preemption: last is 0, so requester 1 wins
      req = 4'b0010;
      tick();
      check("np_first", 8'(gnt), 8'h2);
      req = 4'b1010;
      for (int k = 0; k < 40; k++) begin
         tick();
         check($sformatf("np_hold%0d", k), 8'(gnt), 8'h2);
      end
      req = 4'b1000;
      tick();
      check("np_rel", 8'(gnt), 8'h0);
      tick();
      check("np_next", 8'(gnt), 8'h8);
      check("np_sel", 8'({s1, s0}), 8'h3);
      check("np_y", 8'(y), 8'h1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
